// File: rtl/cache_pkg.sv
// Shared types and constants for the instruction cache.
//   icache_state_t : controller state encoding
//   LINE_BYTES / WORDS_PER_LINE / OFFSET_BITS : line geometry (64 B, 8 x 64-bit words)
//   ICACHE_ID      : requester id placed in the low bits of the arbiter tag
//   ARB_READ/WRITE : value of the arbiter tag MSB
//   idx_width / tag_width : address split helpers
package cache_pkg;

  localparam int LINE_BYTES     = 64;
  localparam int WORDS_PER_LINE = 8;
  localparam int OFFSET_BITS    = 6;

  localparam logic [11:0] ICACHE_ID = 12'h001;
  localparam logic        ARB_READ  = 1'b1;
  localparam logic        ARB_WRITE = 1'b0;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOOKUP,
    S_MISS_REQ,
    S_MISS_WAIT,
    S_RESP
  } icache_state_t;

  function automatic int idx_width(input int num_lines);
    return (num_lines > 1) ? $clog2(num_lines) : 1;
  endfunction

  function automatic int tag_width(input int addr_width, input int num_lines);
    return addr_width - OFFSET_BITS - idx_width(num_lines);
  endfunction

endpackage

// File: rtl/cache_arbiter_bus.sv
// Cache <-> arbiter line-transfer bus.
//   reqcyc/req/reqtag : request from cache (held until reqack)
//   reqack            : arbiter accepted the request
//   respcyc/resp/resptag : returned line; resp bit i is line bit i
interface CacheArbiterBus #(
  parameter int DATA_WIDTH = 512,
  parameter int TAG_WIDTH  = 13,
  parameter int ADDR_WIDTH = 64
);
  logic                  reqcyc;
  logic [ADDR_WIDTH-1:0] req;
  logic [TAG_WIDTH-1:0]  reqtag;
  logic                  reqack;
  logic                  respcyc;
  logic [0:DATA_WIDTH-1] resp;
  logic [TAG_WIDTH-1:0]  resptag;

  modport cache   (output reqcyc, req, reqtag, input  reqack, respcyc, resp, resptag);
  modport arbiter (input  reqcyc, req, reqtag, output reqack, respcyc, resp, resptag);
endinterface

// File: rtl/icache_line_store.sv
// Data/tag arrays plus valid vector for the direct-mapped cache.
//   we/wr_idx/wr_tag/wr_line : install one line and mark it valid
//   flush_all                : clear every valid bit (wins over a write)
//   rd_idx -> rd_valid/rd_tag/rd_line : combinational read port
module icache_line_store #(
  parameter int NUM_LINES = 64,
  parameter int LINE_W    = 512,
  parameter int TAG_W     = 52,
  parameter int IDX_W     = 6
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              we,
  input  logic [IDX_W-1:0]  wr_idx,
  input  logic [TAG_W-1:0]  wr_tag,
  input  logic [LINE_W-1:0] wr_line,
  input  logic              flush_all,
  input  logic [IDX_W-1:0]  rd_idx,
  output logic              rd_valid,
  output logic [TAG_W-1:0]  rd_tag,
  output logic [LINE_W-1:0] rd_line
);

  logic [NUM_LINES-1:0] valid;
  logic [LINE_W-1:0]    data_mem [NUM_LINES];
  logic [TAG_W-1:0]     tag_mem  [NUM_LINES];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)       valid <= '0;
    else if (flush_all) valid <= '0;
    else if (we)        valid[wr_idx] <= 1'b1;
  end

  // Arrays need no reset: the valid vector gates every use.
  always_ff @(posedge clk) begin
    if (we) begin
      data_mem[wr_idx] <= wr_line;
      tag_mem[wr_idx]  <= wr_tag;
    end
  end

  assign rd_valid = valid[rd_idx];
  assign rd_tag   = tag_mem[rd_idx];
  assign rd_line  = data_mem[rd_idx];

endmodule

// File: rtl/mod_icache.sv
// Direct-mapped read-only instruction cache.
//   fetch_req/fetch_addr/fetch_ready : fetch request handshake (IDLE only)
//   fetch_valid/fetch_data           : one-cycle response, data held until next response
//   flush                            : invalidate all lines (deferred to end of an in-flight fetch)
//   hit_count/miss_count             : saturating statistics
//   arb                              : line-fill requests to the cache/memory arbiter
module mod_icache
  import cache_pkg::*;
#(
  parameter int DATA_WIDTH = 512,
  parameter int TAG_WIDTH  = 13,
  parameter int NUM_LINES  = 64,
  parameter int ADDR_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  fetch_req,
  input  logic [ADDR_WIDTH-1:0] fetch_addr,
  output logic                  fetch_ready,
  output logic                  fetch_valid,
  output logic [63:0]           fetch_data,
  input  logic                  flush,
  output logic [31:0]           hit_count,
  output logic [31:0]           miss_count,
  CacheArbiterBus.cache         arb
);

  localparam int IW = idx_width(NUM_LINES);
  localparam int TW = tag_width(ADDR_WIDTH, NUM_LINES);

  icache_state_t state, state_nx;

  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  flush_pend;
  logic [IW-1:0]         idx;
  logic [TW-1:0]         tag;
  logic [8:0]            wbase;
  logic                  rd_valid;
  logic [TW-1:0]         rd_tag;
  logic [DATA_WIDTH-1:0] rd_line;
  logic [DATA_WIDTH-1:0] fill_line;
  logic                  lookup_hit;
  logic                  fill_we;
  logic                  flush_all;
  logic                  unused_ok;

  assign idx   = addr_q[OFFSET_BITS +: IW];
  assign tag   = addr_q[ADDR_WIDTH-1 -: TW];
  assign wbase = {addr_q[5:3], 6'b0};

  // resp is declared ascending; keep bit i of the bus as bit i of the line.
  always_comb begin
    fill_line = '0;
    for (int i = 0; i < DATA_WIDTH; i++) fill_line[i] = arb.resp[i];
  end

  assign lookup_hit = rd_valid && (rd_tag == tag);
  assign fill_we    = (state == S_MISS_WAIT) && arb.respcyc;
  // A flush seen mid-fetch is applied as the fetch retires.
  assign flush_all  = ((state == S_IDLE) && flush) ||
                      ((state == S_RESP) && (flush_pend || flush));

  assign unused_ok = ^{arb.resptag, addr_q[2:0]};

  icache_line_store #(
    .NUM_LINES (NUM_LINES),
    .LINE_W    (DATA_WIDTH),
    .TAG_W     (TW),
    .IDX_W     (IW)
  ) u_store (
    .clk       (clk),
    .reset_n   (reset_n),
    .we        (fill_we),
    .wr_idx    (idx),
    .wr_tag    (tag),
    .wr_line   (fill_line),
    .flush_all (flush_all),
    .rd_idx    (idx),
    .rd_valid  (rd_valid),
    .rd_tag    (rd_tag),
    .rd_line   (rd_line)
  );

  always_comb begin
    state_nx    = state;
    fetch_ready = 1'b0;
    fetch_valid = 1'b0;
    arb.reqcyc  = 1'b0;
    arb.req     = '0;
    arb.reqtag  = '0;
    case (state)
      S_IDLE: begin
        fetch_ready = !flush;
        if (fetch_req && !flush) state_nx = S_LOOKUP;
      end
      S_LOOKUP:   state_nx = lookup_hit ? S_RESP : S_MISS_REQ;
      S_MISS_REQ: begin
        arb.reqcyc                = 1'b1;
        arb.req                   = {addr_q[ADDR_WIDTH-1:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
        arb.reqtag[TAG_WIDTH-1]   = ARB_READ;
        arb.reqtag[11:0]          = ICACHE_ID;
        if (arb.reqack) state_nx = S_MISS_WAIT;
      end
      S_MISS_WAIT: if (arb.respcyc) state_nx = S_RESP;
      S_RESP: begin
        fetch_valid = 1'b1;
        state_nx    = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= S_IDLE;
      addr_q     <= '0;
      fetch_data <= '0;
      flush_pend <= 1'b0;
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      state <= state_nx;
      if (state == S_IDLE && fetch_req && fetch_ready) addr_q <= fetch_addr;
      if (state == S_LOOKUP) begin
        if (lookup_hit) begin
          fetch_data <= rd_line[wbase +: 64];
          if (hit_count != 32'hFFFF_FFFF) hit_count <= hit_count + 32'd1;
        end else if (miss_count != 32'hFFFF_FFFF) begin
          miss_count <= miss_count + 32'd1;
        end
      end
      // Forward the fill directly rather than re-reading the array.
      if (fill_we) fetch_data <= fill_line[wbase +: 64];
      if (state == S_RESP)                 flush_pend <= 1'b0;
      else if (flush && state != S_IDLE)   flush_pend <= 1'b1;
    end
  end

endmodule
